// File: rtl/up5bit_counter_core.sv
// Modulo-N up-counter with enable, synchronous clear, parallel load and terminal-count flag.
// The default configuration is a free-running 5-bit counter that wraps 31 -> 0.
module up5bit_counter_core #(
  parameter int WIDTH    = 5,
  parameter int MODULUS  = 32,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             tc
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_next;
  logic             w_at_last;
  logic             w_load_ok;

  assign w_at_last = (r_count == LAST);
  // Out-of-range load values would leave the count outside 0..MODULUS-1, so they land on 0.
  assign w_load_ok = (load_val <= LAST);

  always_comb begin
    w_next = r_count;
    if (clr) begin
      w_next = '0;
    end else if (load) begin
      w_next = w_load_ok ? load_val : '0;
    end else if (en) begin
      if (!w_at_last) begin
        w_next = r_count + ONE;
      end else if (!SATURATE) begin
        w_next = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else begin
      r_count <= w_next;
    end
  end

  assign out = r_count;
  assign tc  = w_at_last;

endmodule

// File: tb/tb_up5bit_counter_core.sv
// Directed bench for up5bit_counter_core: three configurations share one stimulus stream,
// each output is checked against a reference model through an expected-value queue.
module tb_up5bit_counter_core;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b1;
  logic       clr = 1'b0;
  logic       load = 1'b0;
  logic [4:0] load_val = 5'd0;

  logic [4:0] out0, out1, out2;
  logic       tc0, tc1, tc2;

  int total = 0;
  int bad   = 0;

  logic [5:0] q0[$];
  logic [5:0] q1[$];
  logic [5:0] q2[$];
  logic [4:0] m0 = 5'd0;
  logic [4:0] m1 = 5'd0;
  logic [4:0] m2 = 5'd0;

  up5bit_counter_core dut0 (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .load(load),
    .load_val(load_val), .out(out0), .tc(tc0)
  );

  up5bit_counter_core #(.WIDTH(5), .MODULUS(20), .SATURATE(1'b0)) dut1 (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .load(load),
    .load_val(load_val), .out(out1), .tc(tc1)
  );

  up5bit_counter_core #(.WIDTH(5), .MODULUS(10), .SATURATE(1'b1)) dut2 (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .load(load),
    .load_val(load_val), .out(out2), .tc(tc2)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] nxt(input logic [4:0] cur, input int modulus, input bit sat);
    logic [4:0] last;
    last = 5'(modulus - 1);
    if (!reset) return 5'd0;
    if (clr) return 5'd0;
    if (load) return (load_val <= last) ? load_val : 5'd0;
    if (en) begin
      if (cur == last) return sat ? cur : 5'd0;
      return cur + 5'd1;
    end
    return cur;
  endfunction

  function automatic logic [5:0] pack(input logic [4:0] v, input int modulus);
    return {(v == 5'(modulus - 1)), v};
  endfunction

  task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed={tc,out}=%b/%0d expected={tc,out}=%b/%0d",
             tag, obs[5], obs[4:0], expv[5], expv[4:0]);
    end
  endtask

  task automatic step(input string tag);
    logic [5:0] e;
    q0.push_back(pack(nxt(m0, 32, 1'b0), 32));
    q1.push_back(pack(nxt(m1, 20, 1'b0), 20));
    q2.push_back(pack(nxt(m2, 10, 1'b1), 10));
    @(posedge clk);
    #1;
    e = q0.pop_front(); m0 = e[4:0]; chk({tag, "/d0"}, {tc0, out0}, e);
    e = q1.pop_front(); m1 = e[4:0]; chk({tag, "/d1"}, {tc1, out1}, e);
    e = q2.pop_front(); m2 = e[4:0]; chk({tag, "/d2"}, {tc2, out2}, e);
  endtask

  initial begin
    int k;
    bit reached;

    // Reset hold
    #2 reset = 1'b0;
    #1;
    chk("rst_async", {tc0, out0}, 6'd0);
    for (int i = 0; i < 3; i++) step("rst_hold");
    reset = 1'b1;
    step("rel1");
    chk("rel1_const", {tc0, out0}, {1'b0, 5'd1});
    step("rel2");
    chk("rel2_const", {tc0, out0}, {1'b0, 5'd2});

    // Free-run wrap: 100 edges after release in total
    k = 2;
    for (int i = 0; i < 98; i++) begin
      step("free");
      k++;
      if (k % 32 == 31) chk("free_tc", {tc0, out0}, {1'b1, 5'd31});
      if (k % 32 == 0)  chk("free_wrap", {tc0, out0}, 6'd0);
    end
    chk("free_100", {tc0, out0}, pack(5'(100 % 32), 32));

    // Async reset mid-count at 20
    reached = 1'b0;
    for (int i = 0; i < 64 && !reached; i++) begin
      step("to20");
      reached = (out0 == 5'd20);
    end
    chk("reach20", {tc0, out0}, {1'b0, 5'd20});
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_d0", {tc0, out0}, 6'd0);
    chk("mid_rst_d1", {tc1, out1}, 6'd0);
    chk("mid_rst_d2", {tc2, out2}, 6'd0);
    m0 = 5'd0; m1 = 5'd0; m2 = 5'd0;
    for (int i = 0; i < 5; i++) step("mid_hold");
    reset = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step("resume");
      chk("resume_const", {tc0, out0}, {1'b0, 5'(i)});
    end

    // Enable / hold at 9
    reached = 1'b0;
    for (int i = 0; i < 64 && !reached; i++) begin
      step("to9");
      reached = (out0 == 5'd9);
    end
    chk("reach9", {tc0, out0}, {1'b0, 5'd9});
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step("hold");
      chk("hold_const", {tc0, out0}, {1'b0, 5'd9});
    end
    en = 1'b1;
    step("reen");
    chk("reen_const", {tc0, out0}, {1'b0, 5'd10});

    // Load / clear priority
    load = 1'b1; load_val = 5'd30;
    step("load30");
    chk("load30_const", {tc0, out0}, {1'b0, 5'd30});
    chk("load30_m20", {tc1, out1}, 6'd0);
    load = 1'b0;
    step("after30");
    chk("tc31_const", {tc0, out0}, {1'b1, 5'd31});
    step("wrap0");
    chk("wrap0_const", {tc0, out0}, 6'd0);
    step("pre_clr");
    clr = 1'b1; load = 1'b1; load_val = 5'd12;
    step("clr_load");
    chk("clr_wins", {tc0, out0}, 6'd0);
    clr = 1'b0; load_val = 5'd31;
    step("load31");
    chk("load31_m20", {tc1, out1}, 6'd0);
    chk("load31_m32", {tc0, out0}, {1'b1, 5'd31});
    load_val = 5'd19;
    step("load19");
    chk("load19_m20", {tc1, out1}, {1'b1, 5'd19});
    load = 1'b0;
    step("post_load");

    // Saturate mode (dut2: MODULUS=10, SATURATE=1)
    clr = 1'b1;
    step("sat_clr0");
    clr = 1'b0;
    for (int i = 0; i < 14; i++) step("sat_run");
    chk("sat_hold", {tc2, out2}, {1'b1, 5'd9});
    clr = 1'b1;
    step("sat_clr");
    chk("sat_clr_const", {tc2, out2}, 6'd0);
    clr = 1'b0;
    step("sat_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
